// File: rtl/alu_shifter_seq_if.sv
// alu_shifter_seq_if: request/response bundle for the sequential rotate/shift unit.
//   master : drives start, mode, count, db, cy_in; observes status, result and flags.
//   slave  : the shifter itself.
//   start/mode/count/db/cy_in : request, sampled only while ready=1.
//   ready/busy/done           : handshake status (done is a one-cycle pulse).
//   result/flag_s/z/p/c       : shifted value and Z80-style flags, held until next done.
interface alu_shifter_seq_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 4
);
  logic               start;
  logic [2:0]         mode;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   db;
  logic               cy_in;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               flag_s;
  logic               flag_z;
  logic               flag_p;
  logic               flag_c;

  modport master (
    output start, mode, count, db, cy_in,
    input  ready, busy, done, result, flag_s, flag_z, flag_p, flag_c
  );

  modport slave (
    input  start, mode, count, db, cy_in,
    output ready, busy, done, result, flag_s, flag_z, flag_p, flag_c
  );
endinterface

// File: rtl/alu_shifter_seq.sv
// alu_shifter_seq: multi-cycle Z80 rotate/shift unit (RLC, RRC, RL, RR, SLA, SRA,
// SLL, SRL), one bit position per clock, with S/Z/P/C flags and start/done handshake.
//   clk   : system clock, rising edge.
//   reset : synchronous, active-high.
//   bus   : alu_shifter_seq_if slave port (request, status, result, flags).
module alu_shifter_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 4
) (
  input logic              clk,
  input logic              reset,
  alu_shifter_seq_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] MODE_RLC = 3'd0;
  localparam logic [2:0] MODE_RRC = 3'd1;
  localparam logic [2:0] MODE_RL  = 3'd2;
  localparam logic [2:0] MODE_RR  = 3'd3;
  localparam logic [2:0] MODE_SLA = 3'd4;
  localparam logic [2:0] MODE_SRA = 3'd5;
  localparam logic [2:0] MODE_SLL = 3'd6;
  localparam logic [2:0] MODE_SRL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_w;
  logic               r_c;
  logic [2:0]         r_mode;
  logic [COUNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_flag_s;
  logic               r_flag_z;
  logic               r_flag_p;
  logic               r_flag_c;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_step_w;
  logic               w_step_c;

  // One single-bit step of the captured mode applied to the working register/carry.
  always_comb begin
    w_step_w = r_w;
    w_step_c = r_c;
    case (r_mode)
      MODE_RLC: begin
        w_step_c = r_w[MSB];
        w_step_w = {r_w[MSB-1:0], r_w[MSB]};
      end
      MODE_RRC: begin
        w_step_c = r_w[0];
        w_step_w = {r_w[0], r_w[MSB:1]};
      end
      MODE_RL: begin
        w_step_c = r_w[MSB];
        w_step_w = {r_w[MSB-1:0], r_c};
      end
      MODE_RR: begin
        w_step_c = r_w[0];
        w_step_w = {r_c, r_w[MSB:1]};
      end
      MODE_SLA: begin
        w_step_c = r_w[MSB];
        w_step_w = {r_w[MSB-1:0], 1'b0};
      end
      MODE_SRA: begin
        w_step_c = r_w[0];
        w_step_w = {r_w[MSB], r_w[MSB:1]};
      end
      MODE_SLL: begin
        w_step_c = r_w[MSB];
        w_step_w = {r_w[MSB-1:0], 1'b1};
      end
      MODE_SRL: begin
        w_step_c = r_w[0];
        w_step_w = {1'b0, r_w[MSB:1]};
      end
      default: begin
        w_step_w = r_w;
        w_step_c = r_c;
      end
    endcase
  end

  // Control FSM, working datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_w      <= '0;
      r_c      <= 1'b0;
      r_mode   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flag_s <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_p <= 1'b0;
      r_flag_c <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (bus.start) begin
            r_w    <= bus.db;
            r_c    <= bus.cy_in;
            r_mode <= bus.mode;
            r_cnt  <= bus.count;
            if (bus.count == '0) begin
              // Zero count: operand and carry-in pass straight through.
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_result <= bus.db;
              r_flag_s <= bus.db[MSB];
              r_flag_z <= (bus.db == '0);
              r_flag_p <= ~^bus.db;
              r_flag_c <= bus.cy_in;
            end else begin
              r_state <= ST_SHIFT;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_w   <= w_step_w;
          r_c   <= w_step_c;
          r_cnt <= r_cnt - COUNT_W'(1);
          if (r_cnt == COUNT_W'(1)) begin
            // Final step: publish the stepped value directly.
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= w_step_w;
            r_flag_s <= w_step_w[MSB];
            r_flag_z <= (w_step_w == '0);
            r_flag_p <= ~^w_step_w;
            r_flag_c <= w_step_c;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.flag_s = r_flag_s;
  assign bus.flag_z = r_flag_z;
  assign bus.flag_p = r_flag_p;
  assign bus.flag_c = r_flag_c;

endmodule

// File: tb/tb_alu_shifter_seq.sv
// tb_alu_shifter_seq: scoreboard bench for alu_shifter_seq. Stimulus pushes expected
// responses from an arithmetic reference model; a monitor pops and compares on done.
module tb_alu_shifter_seq;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int TOP  = 1 << (W - 1);
  localparam int FULL = 1 << W;

  typedef struct {
    int res;
    int c;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sbq[$];

  alu_shifter_seq_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

  alu_shifter_seq #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: shifts computed on integers with multiply/divide/modulo.
  function automatic void model(input int m, input int n, input int d, input int cin,
                                output int res, output int c);
    int v;
    int cc;
    int old;
    int s;
    v  = d;
    cc = cin;
    for (int k = 0; k < n; k++) begin
      old = cc;
      s   = v / TOP;
      case (m)
        0: begin cc = s;     v = (v * 2) % FULL + s;    end
        1: begin cc = v % 2; v = v / 2 + (v % 2) * TOP; end
        2: begin cc = s;     v = (v * 2) % FULL + old;  end
        3: begin cc = v % 2; v = v / 2 + old * TOP;     end
        4: begin cc = s;     v = (v * 2) % FULL;        end
        5: begin cc = v % 2; v = v / 2 + s * TOP;       end
        6: begin cc = s;     v = (v * 2) % FULL + 1;    end
        default: begin cc = v % 2; v = v / 2;           end
      endcase
    end
    res = v;
    c   = cc;
  endfunction

  // Monitor: handshake sanity every cycle, scoreboard compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("ready_xor_busy", int'(bus.ready ^ bus.busy), 1);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("result", int'(bus.result), e.res);
          chk("flag_c", int'(bus.flag_c), e.c);
          chk("flag_s", int'(bus.flag_s), (e.res / TOP) % 2);
          chk("flag_z", int'(bus.flag_z), (e.res == 0) ? 1 : 0);
          chk("flag_p", int'(bus.flag_p), ($countones(e.res) % 2 == 0) ? 1 : 0);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; waits for ready, presents one request for one edge.
  task automatic issue(input int m, input int n, input int d, input int cin, input bit push);
    int waited;
    int r;
    int c;
    waited = 0;
    while (!bus.ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.start = 1'b1;
    bus.mode  = 3'(m);
    bus.count = CW'(n);
    bus.db    = W'(d);
    bus.cy_in = 1'(cin);
    if (push) begin
      model(m, n, d, cin, r, c);
      sbq.push_back('{r, c, cyc + 1 + n});
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Drives a bogus request for one cycle while the unit is busy; it must be dropped.
  task automatic poke_busy();
    if (bus.busy) begin
      bus.start = 1'b1;
      bus.mode  = 3'($urandom_range(0, 7));
      bus.count = CW'(1);
      bus.db    = W'($urandom_range(0, 255));
      bus.cy_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_empty", sbq.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string name, input int res, input int c);
    chk({name, "_result"}, int'(bus.result), res);
    chk({name, "_flag_c"}, int'(bus.flag_c), c);
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 3'd0;
    bus.count = '0;
    bus.db    = '0;
    bus.cy_in = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_flags", int'({bus.flag_s, bus.flag_z, bus.flag_p, bus.flag_c}), 0);
    reset = 1'b0;
    @(negedge clk);

    // RLC 0x81 by 1.
    issue(0, 1, 'h81, 0, 1);
    chk("rlc_busy_t1", int'(bus.busy), 1);
    drain();
    chk_outs("rlc", 'h03, 1);
    chk("rlc_flags_szp", int'({bus.flag_s, bus.flag_z, bus.flag_p}), 3'b001);

    // SRA 0x80 by 3 with an ignored start while busy.
    issue(5, 3, 'h80, 0, 1);
    poke_busy();
    drain();
    chk_outs("sra", 'hF0, 0);
    chk("sra_flags_sp", int'({bus.flag_s, bus.flag_p}), 2'b11);

    // RR then back-to-back SRL accepted in the DONE cycle.
    issue(3, 1, 'h01, 1, 1);
    issue(7, 1, 'h01, 0, 1);
    drain();
    chk_outs("srl_b2b", 'h00, 1);
    chk("srl_b2b_zp", int'({bus.flag_z, bus.flag_p}), 2'b11);

    // Zero count passes operand and carry-in through without a busy cycle.
    issue(2, 0, 'h5A, 1, 1);
    chk("cnt0_busy", int'(bus.busy), 0);
    chk("cnt0_done", int'(bus.done), 1);
    drain();
    chk_outs("cnt0", 'h5A, 1);

    // Counts beyond WIDTH: saturation and full-rotation wrap.
    issue(6, 9, 'h00, 0, 1);
    drain();
    chk_outs("sll9", 'hFF, 1);
    issue(0, 8, 'hA5, 0, 1);
    drain();
    chk_outs("rlc8", 'hA5, 1);

    // Reset in the 2nd busy cycle aborts with no done pulse.
    issue(4, 5, 'hFF, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_flags", int'({bus.flag_s, bus.flag_z, bus.flag_p, bus.flag_c}), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (10) @(negedge clk);

    // Randomised traffic, with occasional ignored starts and idle gaps.
    for (int i = 0; i < 80; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 1), 1);
      if ($urandom_range(0, 3) == 0) poke_busy();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_shifter_seq.md
Name: alu_shifter_seq

Overview:
- Parametrised, multi-cycle successor to the combinational ALU shifter core.
- Performs all Z80 rotate/shift modes (RLC, RRC, RL, RR, SLA, SRA, SLL, SRL) on a WIDTH-bit operand by a programmable count, one bit position per clock.
- Produces the result plus Z80-style S/Z/P/C flags, with a start/done handshake.
- Sits beside the ALU core and serves extended multi-bit shift micro-ops and block-level test.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- COUNT_W, 4, width of the shift-count input; legal counts 0 .. 2^COUNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- mode  input  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
- count  input  COUNT_W  number of single-bit steps.
- db  input  WIDTH  operand, captured with start.
- cy_in  input  1  carry-in, captured with start; used by RL/RR.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high in state SHIFT.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  shifted value, held until the next done or reset.
- flag_s  output  1  result[WIDTH-1].
- flag_z  output  1  result == 0.
- flag_p  output  1  even parity of result (1 = even number of ones).
- flag_c  output  1  last bit shifted out; cy_in when count = 0.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE; result = 0; all flags = 0; done = 0; busy = 0; ready = 1.
  - Internal working register, carry and counter are cleared.
  - Reset overrides start in the same cycle.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: start=1 captures db, cy_in, mode, count. Next state is SHIFT if count != 0, else DONE.
  - SHIFT: each cycle applies one step to the working register and decrements the counter. When the counter reaches 1 and that step is taken, next state is DONE.
  - DONE: done=1; result and flags are loaded from the working register/carry on the IDLE/SHIFT->DONE edge. A start=1 in DONE is accepted exactly as in IDLE (back-to-back). Otherwise next state is IDLE.
- Latency: start accepted at edge T with count N >= 1 → busy high for cycles T+1..T+N, done at T+N+1. With count 0 → done at T+1 and result = db, flag_c = cy_in.
- Start while busy=1 is ignored: no capture, no queuing.
- Per-step rules (w = working register, c = working carry, MSB = bit WIDTH-1):
  - RLC: c = w[MSB]; w = {w[MSB-1:0], w[MSB]}.
  - RRC: c = w[0]; w = {w[0], w[MSB:1]}.
  - RL: c = w[MSB]; w = {w[MSB-1:0], old c}.
  - RR: c = w[0]; w = {old c, w[MSB:1]}.
  - SLA: c = w[MSB]; shift in 0 at LSB.
  - SLL: c = w[MSB]; shift in 1 at LSB.
  - SRA: c = w[0]; MSB duplicated.
  - SRL: c = w[0]; shift in 0 at MSB.
- Working carry is initialised to cy_in at capture for all modes.
- Counts larger than WIDTH are legal:
  - Rotates wrap naturally.
  - SLA/SRL saturate to 0; SLL saturates to all ones; SRA saturates to all sign bits.
  - Carry follows the step rules exactly.
- result and flags change only on entry to DONE or on reset. Inputs are not observed outside the capture cycle.
- Reset mid-SHIFT aborts immediately: no done pulse, outputs cleared as above, ready next cycle.
- ready and busy are mutually exclusive and are decoded from registered state, never directly from inputs.

Test Plan:
- Reset, then RLC, db=8'h81, cy_in=0, count=1, start at T → busy at T+1, done at T+2, result=8'h03, flag_c=1, flag_s=0, flag_z=0, flag_p=1.
- SRA, db=8'h80, count=3 → done at T+4, result=8'hF0, flag_c=0, flag_s=1, flag_p=1; a start pulsed at T+2 (busy) is ignored and result is unchanged.
- RR, db=8'h01, cy_in=1, count=1 → result=8'h80, flag_c=1.
  - Then back-to-back start in the DONE cycle: SRL, db=8'h01, count=1 → second done two cycles later, result=8'h00, flag_z=1, flag_p=1, flag_c=1.
- count=0, db=8'h5A, cy_in=1, any mode → done at T+1, result=8'h5A, flag_c=1, busy never high.
- SLL, db=8'h00, count=9 (> WIDTH) → result=8'hFF, flag_c=1.
  - Then RLC, db=8'hA5, count=8 → result=8'hA5, flag_c=1.
- SLA, db=8'hFF, count=5; assert reset in the 2nd busy cycle → next cycle busy=0, ready=1, result=8'h00, all flags 0, no done pulse at any later cycle.
